// File: rtl/dma_mem_slave.sv
// Word-organised memory target for a DMA master port: programmable wait states before mem_ready,
// fault reporting for bad addresses and conflicting strobes, plus a host backdoor port.
module dma_mem_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [31:0]              i_mem_addr,
    input  logic [31:0]              i_mem_wdata,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,
    output logic                     o_mem_ready,
    output logic [31:0]              o_mem_rdata,
    output logic                     o_mem_err,
    input  logic                     i_cfg_we,
    input  logic [$clog2(DEPTH)-1:0] i_cfg_idx,
    input  logic [31:0]              i_cfg_wdata,
    output logic [31:0]              o_cfg_rdata
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [31:0] r_mem [DEPTH];
    logic          r_op_read;
    logic          r_fault;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [7:0]    r_cnt;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [31:0]   r_cfg_rdata;

    logic [31:0] w_off;
    logic        w_fault;
    logic        w_capture;
    logic        w_complete;
    logic        w_consume;
    logic        w_dma_we;

    // Span check is done in 33 bits so a window at the top of the address map cannot wrap.
    always_comb begin
        w_off   = i_mem_addr - BASE_ADDR;
        w_fault = (i_mem_addr[1:0] != 2'b00) || (i_mem_addr < BASE_ADDR) ||
                  ({1'b0, w_off} >= SPAN) || (i_mem_read && i_mem_write);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        w_consume    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_mem_read || i_mem_write) begin
                    w_capture    = 1'b1;
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (r_cnt == 8'd0) begin
                    w_complete   = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (r_op_read ? i_mem_read : i_mem_write) begin
                    w_consume    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op_read   <= 1'b0;
            r_fault     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_cfg_rdata <= '0;
        end else begin
            r_cfg_rdata <= r_mem[i_cfg_idx];
            if (w_capture) begin
                r_op_read <= i_mem_read;
                r_fault   <= w_fault;
                r_idx     <= w_off[IW+1:2];
                r_wdata   <= i_mem_wdata;
                r_cnt     <= 8'(WAIT_STATES);
            end
            if (r_state == StBusy && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_complete) begin
                r_ready <= 1'b1;
                r_err   <= r_fault;
                if (r_fault) begin
                    r_rdata <= '0;
                end else if (r_op_read) begin
                    r_rdata <= r_mem[r_idx];
                end
            end
            if (w_consume) begin
                r_ready <= 1'b0;
                r_err   <= 1'b0;
            end
        end
    end

    assign w_dma_we = w_complete && !r_op_read && !r_fault;

    // DMA write is the later assignment, so it overrides a same-word backdoor write.
    always_ff @(posedge i_clk) begin
        if (i_cfg_we) begin
            r_mem[i_cfg_idx] <= i_cfg_wdata;
        end
        if (w_dma_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign o_mem_ready = r_ready;
    assign o_mem_rdata = r_rdata;
    assign o_mem_err   = r_err;
    assign o_cfg_rdata = r_cfg_rdata;
endmodule

// File: tb/tb_dma_mem_slave.sv
// Bench for dma_mem_slave: two instances (2 and 0 wait states) checked every cycle against a
// transaction-level model, plus directed scenarios with hand-computed values.
module tb_dma_mem_slave;
    localparam int DEPTH = 256;
    localparam longint BASE = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        rdy [2];
    logic [31:0] rdat [2];
    logic        err [2];
    logic        cfg_we [2];
    logic [7:0]  cfg_idx [2];
    logic [31:0] cfg_wd [2];
    logic [31:0] cfg_rd [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    dma_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut_ws2 (
        .i_clk(clk), .i_reset(reset), .i_mem_addr(addr[0]), .i_mem_wdata(wdata[0]),
        .i_mem_read(rd[0]), .i_mem_write(wr[0]), .o_mem_ready(rdy[0]), .o_mem_rdata(rdat[0]),
        .o_mem_err(err[0]), .i_cfg_we(cfg_we[0]), .i_cfg_idx(cfg_idx[0]),
        .i_cfg_wdata(cfg_wd[0]), .o_cfg_rdata(cfg_rd[0])
    );

    dma_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut_ws0 (
        .i_clk(clk), .i_reset(reset), .i_mem_addr(addr[1]), .i_mem_wdata(wdata[1]),
        .i_mem_read(rd[1]), .i_mem_write(wr[1]), .o_mem_ready(rdy[1]), .o_mem_rdata(rdat[1]),
        .o_mem_err(err[1]), .i_cfg_we(cfg_we[1]), .i_cfg_idx(cfg_idx[1]),
        .i_cfg_wdata(cfg_wd[1]), .o_cfg_rdata(cfg_rd[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: access timeline by edge count ----------------
    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic is_fault(input logic [31:0] a, input logic both);
        return (a[1:0] != 2'b00) || (64'(a) < BASE) || (64'(a) >= BASE + DEPTH * 4) || both;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((64'(a) - BASE) >> 2) % DEPTH);
    endfunction

    logic [31:0] m_mem [2][DEPTH];
    logic        m_busy [2];
    logic        m_ready [2];
    logic        m_err [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_cfg_rdata [2];
    logic        m_is_rd [2];
    logic        m_fault [2];
    int          m_idx [2];
    logic [31:0] m_wd [2];
    int          m_cap [2];
    int          ecnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d]      <= 1'b0;
                m_ready[d]     <= 1'b0;
                m_err[d]       <= 1'b0;
                m_rdata[d]     <= '0;
                m_cfg_rdata[d] <= '0;
            end
        end else begin
            ecnt <= ecnt + 1;
            for (int d = 0; d < 2; d++) begin
                m_cfg_rdata[d] <= m_mem[d][cfg_idx[d]];
                if (cfg_we[d]) m_mem[d][cfg_idx[d]] <= cfg_wd[d];
                if (!m_busy[d]) begin
                    if (rd[d] || wr[d]) begin
                        m_busy[d]  <= 1'b1;
                        m_is_rd[d] <= rd[d];
                        m_fault[d] <= is_fault(addr[d], rd[d] && wr[d]);
                        m_idx[d]   <= widx(addr[d]);
                        m_wd[d]    <= wdata[d];
                        m_cap[d]   <= ecnt;
                    end
                end else if (!m_ready[d]) begin
                    if (ecnt == m_cap[d] + ws_of(d) + 1) begin
                        m_ready[d] <= 1'b1;
                        m_err[d]   <= m_fault[d];
                        if (m_fault[d]) m_rdata[d] <= '0;
                        else if (m_is_rd[d]) m_rdata[d] <= m_mem[d][m_idx[d]];
                        else m_mem[d][m_idx[d]] <= m_wd[d];
                    end
                end else if (m_is_rd[d] ? rd[d] : wr[d]) begin
                    m_ready[d] <= 1'b0;
                    m_err[d]   <= 1'b0;
                    m_busy[d]  <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_ready%0d", d), 32'(rdy[d]), 32'(m_ready[d]));
                chk($sformatf("model_err%0d", d), 32'(err[d]), 32'(m_err[d]));
                chk($sformatf("model_rdata%0d", d), rdat[d], m_rdata[d]);
                chk($sformatf("model_cfg_rdata%0d", d), cfg_rd[d], m_cfg_rdata[d]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_lat, input logic exp_err,
                          input logic chk_data, input logic [31:0] exp_data,
                          output logic [31:0] got);
        int lat;
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
        tick();
        lat = 0;
        while (rdy[d] !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(err[d]), 32'(exp_err));
        if (chk_data) chk("rdata", rdat[d], exp_data);
        got = rdat[d];
        tick();
        rd[d] = 1'b0; wr[d] = 1'b0;
        chk("consumed", 32'(rdy[d]), 32'd0);
    endtask

    task automatic cfg_peek(input int d, input int idx, input logic [31:0] exp);
        cfg_idx[d] = 8'(idx);
        tick();
        chk($sformatf("cfg_rdata[%0d]", idx), cfg_rd[d], exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] tmp;
        logic        tog_rd [6];
        logic        tog_rdy [6];
        tog_rd  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tog_rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            cfg_we[d] = 1'b0; cfg_idx[d] = '0; cfg_wd[d] = '0;
        end
        #2 reset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_rdata", rdat[d], 32'd0);
            chk("reset_err", 32'(err[d]), 32'd0);
            chk("reset_cfg_rdata", cfg_rd[d], 32'd0);
        end
        reset = 1'b0;
        tick();

        // preload: instance 0 holds A500_00ii, instance 1 holds B600_00ii
        for (int i = 0; i < DEPTH; i++) begin
            cfg_we[0] = 1'b1; cfg_idx[0] = 8'(i); cfg_wd[0] = 32'hA500_0000 | 32'(i);
            cfg_we[1] = 1'b1; cfg_idx[1] = 8'(i); cfg_wd[1] = 32'hB600_0000 | 32'(i);
            tick();
        end
        cfg_we[0] = 1'b0; cfg_we[1] = 1'b0;
        tick();
        chk_en = 1'b1;

        // 1: backdoor preload then read, 3-edge latency
        cfg_we[0] = 1'b1; cfg_idx[0] = 8'd4; cfg_wd[0] = 32'hDEAD_BEEF;
        tick();
        cfg_we[0] = 1'b0;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, got);

        // 2: DMA write, inspect through backdoor
        access(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0, got);
        cfg_peek(0, 8, 32'h1234_5678);

        // 3: toggling read strobe, single access
        rd[0] = 1'b1; addr[0] = 32'h14;
        tick();
        for (int i = 0; i < 6; i++) begin
            rd[0] = tog_rd[i];
            tick();
            chk($sformatf("toggle_ready%0d", i), 32'(rdy[0]), 32'(tog_rdy[i]));
        end
        rd[0] = 1'b0;
        chk("toggle_rdata_held", rdat[0], 32'hA500_0005);
        tick();
        chk("toggle_no_recapture", 32'(rdy[0]), 32'd0);

        // 4: faults
        access(0, 1'b1, 1'b0, 32'h402, 32'h0, 3, 1'b1, 1'b1, 32'h0, got);
        access(0, 1'b0, 1'b1, 32'h400, 32'h5555_AAAA, 3, 1'b1, 1'b1, 32'h0, got);
        cfg_peek(0, 0, 32'hA500_0000);
        access(0, 1'b1, 1'b1, 32'h18, 32'h7777_7777, 3, 1'b1, 1'b1, 32'h0, got);
        cfg_peek(0, 6, 32'hA500_0006);

        // 5: zero wait states, copy burst 0x00 -> 0x40
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b1, 1'b0, 32'(4 * i), 32'h0, 1, 1'b0, 1'b1, 32'hB600_0000 + 32'(i), got);
            access(1, 1'b0, 1'b1, 32'h40 + 32'(4 * i), got, 1, 1'b0, 1'b0, 32'h0, tmp);
        end
        for (int i = 0; i < 4; i++) cfg_peek(1, 16 + i, 32'hB600_0000 + 32'(i));

        // 6: reset during a BUSY write (instance 0) and a RESP read (instance 1)
        wr[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFE_F00D;
        rd[1] = 1'b1; addr[1] = 32'h8;
        tick();
        tick();
        chk("resp_before_reset", 32'(rdy[1]), 32'd1);
        #2;
        reset = 1'b1;
        wr[0] = 1'b0; rd[1] = 1'b0;
        #1;
        chk("async_drop0", 32'(rdy[0]), 32'd0);
        chk("async_drop1", 32'(rdy[1]), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        cfg_peek(0, 12, 32'hA500_000C);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 3, 1'b0, 1'b1, 32'hA500_000C, got);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
